// File: rtl/riscv_run_controller.sv
// Run-control sequencer for a single-cycle RISC-V core: reset hold, clock-enable
// gating in free-run / single-step / run-for-N, and breakpoint / self-loop / budget halts.
module riscv_run_controller #(
  parameter int XLEN         = 32,
  parameter int CNT_W        = 32,
  parameter int RESET_CYCLES = 4,
  parameter int NUM_BP       = 2,
  parameter int HALT_WINDOW  = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             mode,
  input  logic                   start,
  input  logic                   stop,
  input  logic [CNT_W-1:0]       step_count,
  input  logic [NUM_BP*XLEN-1:0] bp_addr,
  input  logic [NUM_BP-1:0]      bp_en,
  input  logic [XLEN-1:0]        core_pc,
  output logic                   core_reset_n,
  output logic                   core_ce,
  output logic                   busy,
  output logic                   halted,
  output logic [2:0]             halt_cause,
  output logic [CNT_W-1:0]       cycle_count
);

  localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int STAB_W = $clog2(HALT_WINDOW + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(HALT_WINDOW);

  localparam logic [2:0] CAUSE_NONE   = 3'd0;
  localparam logic [2:0] CAUSE_STOP   = 3'd1;
  localparam logic [2:0] CAUSE_BP     = 3'd2;
  localparam logic [2:0] CAUSE_LOOP   = 3'd3;
  localparam logic [2:0] CAUSE_BUDGET = 3'd4;

  typedef enum logic [1:0] {
    ST_RST_HOLD = 2'd0,
    ST_IDLE     = 2'd1,
    ST_RUN      = 2'd2,
    ST_HALT     = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
  logic [CNT_W-1:0]  budget_q, budget_d;
  logic              budgeted_q, budgeted_d;
  logic              first_q, first_d;
  logic [STAB_W-1:0] stable_q, stable_d;
  logic [XLEN-1:0]   last_pc_q, last_pc_d;
  logic [2:0]        halt_cause_q, halt_cause_d;
  logic              core_reset_n_q, core_reset_n_d;
  logic              core_ce_q, core_ce_d;
  logic              busy_q, busy_d;
  logic              halted_q, halted_d;
  logic              bp_hit;
  logic [2:0]        cause;

  always_comb begin
    bp_hit = 1'b0;
    for (int i = 0; i < NUM_BP; i++) begin
      if (bp_en[i] && (bp_addr[i*XLEN +: XLEN] == core_pc)) begin
        bp_hit = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    cycle_count_d = cycle_count_q;
    budget_d      = budget_q;
    budgeted_d    = budgeted_q;
    first_d       = first_q;
    stable_d      = stable_q;
    last_pc_d     = last_pc_q;
    halt_cause_d  = halt_cause_q;
    cause         = CAUSE_NONE;

    case (state_q)
      ST_RST_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = ST_IDLE;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_IDLE, ST_HALT: begin
        if (start) begin
          cycle_count_d = '0;
          halt_cause_d  = CAUSE_NONE;
          stable_d      = '0;
          first_d       = 1'b1;
          budgeted_d    = (mode == 2'd1) || (mode == 2'd2);
          if (mode == 2'd2) begin
            budget_d = step_count;
          end else if (mode == 2'd1) begin
            budget_d = CNT_W'(1);
          end else begin
            budget_d = '0;
          end
          if ((mode == 2'd2) && (step_count == '0)) begin
            state_d      = ST_HALT;
            halt_cause_d = CAUSE_BUDGET;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        if (cycle_count_q != '1) begin
          cycle_count_d = cycle_count_q + CNT_W'(1);
        end else begin
          cycle_count_d = cycle_count_q;
        end
        if (budgeted_q && (budget_q != '0)) begin
          budget_d = budget_q - CNT_W'(1);
        end else begin
          budget_d = budget_q;
        end
        // stable_q==0 marks the first executed cycle since start
        if ((stable_q == '0) || (core_pc != last_pc_q)) begin
          stable_d = STAB_W'(1);
        end else if (stable_q != STAB_MAX) begin
          stable_d = stable_q + STAB_W'(1);
        end else begin
          stable_d = stable_q;
        end
        first_d   = 1'b0;
        last_pc_d = core_pc;

        if (stop) begin
          cause = CAUSE_STOP;
        end else if (!first_q && bp_hit) begin
          cause = CAUSE_BP;
        end else if (stable_d == STAB_MAX) begin
          cause = CAUSE_LOOP;
        end else if (budgeted_q && (budget_d == '0)) begin
          cause = CAUSE_BUDGET;
        end else begin
          cause = CAUSE_NONE;
        end

        if (cause != CAUSE_NONE) begin
          state_d      = ST_HALT;
          halt_cause_d = cause;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RST_HOLD;
      end
    endcase

    core_reset_n_d = (state_d != ST_RST_HOLD);
    core_ce_d      = (state_d == ST_RUN);
    busy_d         = (state_d == ST_RUN);
    halted_d       = (state_d == ST_HALT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_RST_HOLD;
      hold_q         <= '0;
      cycle_count_q  <= '0;
      budget_q       <= '0;
      budgeted_q     <= 1'b0;
      first_q        <= 1'b0;
      stable_q       <= '0;
      last_pc_q      <= '0;
      halt_cause_q   <= CAUSE_NONE;
      core_reset_n_q <= 1'b0;
      core_ce_q      <= 1'b0;
      busy_q         <= 1'b0;
      halted_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      hold_q         <= hold_d;
      cycle_count_q  <= cycle_count_d;
      budget_q       <= budget_d;
      budgeted_q     <= budgeted_d;
      first_q        <= first_d;
      stable_q       <= stable_d;
      last_pc_q      <= last_pc_d;
      halt_cause_q   <= halt_cause_d;
      core_reset_n_q <= core_reset_n_d;
      core_ce_q      <= core_ce_d;
      busy_q         <= busy_d;
      halted_q       <= halted_d;
    end
  end

  assign core_reset_n = core_reset_n_q;
  assign core_ce      = core_ce_q;
  assign busy         = busy_q;
  assign halted       = halted_q;
  assign halt_cause   = halt_cause_q;
  assign cycle_count  = cycle_count_q;

endmodule

// File: doc/riscv_run_controller.md
Name: riscv_run_controller

Overview:
Synthesizable run-control sequencer that sits between the board/bench clock-reset source and the single-cycle RISC-V core. It holds the core in reset for a programmable number of cycles, then gates the core's clock enable in free-run, single-step or run-for-N mode. It stops the core on a PC breakpoint or on a self-loop (halt) and reports the executed cycle count and the stop cause. It replaces ad-hoc delay-based reset/run generation with a cycle-exact, parametrised controller usable both in simulation and on hardware.

Parameters:
XLEN, 32, width of the core program counter
CNT_W, 32, width of the cycle counter and the step_count operand
RESET_CYCLES, 4, cycles core_reset_n is held low after controller reset (must be >=1)
NUM_BP, 2, number of PC breakpoint comparators (>=1)
HALT_WINDOW, 3, consecutive enabled cycles with unchanged PC that declare a halt (>=2)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high controller reset
mode  in  2  0=free-run, 1=single-step, 2=run-for-N, 3=reserved (treated as free-run)
start  in  1  one-cycle pulse; launches a run from IDLE or HALT
stop  in  1  one-cycle pulse; forces HALT from RUN
step_count  in  CNT_W  cycle budget for mode 2, sampled on accepted start
bp_addr  in  NUM_BP*XLEN  breakpoint addresses, slot i at bits [i*XLEN +: XLEN]
bp_en  in  NUM_BP  per-slot breakpoint enable
core_pc  in  XLEN  current PC of the core
core_reset_n  out  1  active-low reset to the core
core_ce  out  1  core clock enable; the core advances one instruction per cycle with core_ce=1
busy  out  1  high in RUN
halted  out  1  high in HALT
halt_cause  out  3  0=none, 1=stop, 2=breakpoint, 3=self-loop, 4=budget exhausted
cycle_count  out  CNT_W  core_ce-high cycles since the last accepted start

Behaviour:
- States: RST_HOLD, IDLE, RUN, HALT. On reset=1: state RST_HOLD, hold counter=0, core_reset_n=0, core_ce=0, busy=0, halted=0, halt_cause=0, cycle_count=0, internal budget=0, stable-PC counter=0.
- RST_HOLD: core_reset_n=0 for exactly RESET_CYCLES cycles after reset deasserts, then core_reset_n=1 and the controller enters IDLE. start/stop are ignored in RST_HOLD.
- IDLE/HALT: core_ce=0. An accepted start enters RUN on the next cycle, clears cycle_count, halt_cause and the stable-PC counter, and loads the budget (mode 2: step_count; mode 1: 1). start with mode 2 and step_count=0 goes directly to HALT with cause 4; core_ce never asserts.
- RUN: core_ce=1 every cycle, busy=1, cycle_count increments on each core_ce cycle and saturates at all-ones (no wrap).
- Stop-condition checks, evaluated on each RUN cycle after that cycle's execution. Priority when several hold in the same cycle: stop(1) > breakpoint(2) > self-loop(3) > budget(4).
  - Breakpoint: core_pc == bp_addr[i] with bp_en[i]=1, checked on the PC presented at the start of each RUN cycle except the first cycle after start. This lets execution resume from a breakpoint.
  - Self-loop: core_pc has been unchanged for HALT_WINDOW consecutive core_ce cycles.
  - Budget: in modes 1 and 2, the budget decrements per core_ce cycle and triggers when it reaches 0.
- When a stop condition triggers, core_ce drops on the following cycle, state becomes HALT, halted=1, and halt_cause latches the cause. The triggering cycle counts as executed.
- Mode 1 = run-for-1, so each start yields exactly one core_ce pulse, halted with cause 4.
- start while in RUN: ignored. stop outside RUN: ignored. mode changes during RUN take no effect until the next start.
- Simultaneous start and stop in IDLE/HALT: start wins (stop is only meaningful in RUN).
- reset asserted mid-run: immediate return to RST_HOLD on the next edge; all outputs take their reset values; the reset hold sequence reruns.

Test Plan:
1. Reset pulse, RESET_CYCLES=4 -> core_reset_n low for 4 cycles after reset falls, then IDLE with core_ce=0 and halted=0.
2. Mode 2, step_count=10, start, PC incrementing by 4 -> exactly 10 core_ce cycles, cycle_count=10, halted=1, halt_cause=4.
3. Mode 0, bp_en=01, bp_addr[0]=0x20, PC from 0 stepping by 4 -> halt after the cycle where PC=0x20, cause 2. A second start resumes without re-triggering at 0x20.
4. Mode 0, PC stuck at 0x3C (jal x0,0) -> halted with cause 3 after 3 cycles of unchanged PC. Then stop pulsed in IDLE -> no effect.
5. Mode 1, three start pulses spaced 5 cycles apart -> three single core_ce pulses, cycle_count=1 after each, cause 4.
6. Mode 0 run, stop and breakpoint hit in the same cycle -> cause 1. Then reset asserted mid-run -> core_ce=0 and core_reset_n=0 next cycle, and the hold sequence restarts; mode 2 with step_count=0 -> immediate HALT, cause 4, no core_ce.
